// File: rtl/fft_peak_detect_if.sv
// fft_peak_detect_if: bin stream, control and peak result bundle for fft_peak_detect
interface fft_peak_detect_if;
  logic        i_start;
  logic        i_in_valid;
  logic [31:0] i_in_data;
  logic [32:0] i_min_mag;
  logic        o_in_ready;
  logic        o_busy;
  logic        o_done;
  logic [5:0]  o_peak_bin;
  logic [32:0] o_peak_mag;
  logic        o_peak_found;
  modport master (
    output i_start, i_in_valid, i_in_data, i_min_mag,
    input  o_in_ready, o_busy, o_done, o_peak_bin, o_peak_mag, o_peak_found
  );
  modport slave (
    input  i_start, i_in_valid, i_in_data, i_min_mag,
    output o_in_ready, o_busy, o_done, o_peak_bin, o_peak_mag, o_peak_found
  );
endinterface

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: streaming peak-bin finder over bins SEARCH_LO..SEARCH_HI; PEAK_SQMAG_EN selects re^2+im^2 magnitude
module fft_peak_detect #(
  parameter int NBINS     = 64,
  parameter int SEARCH_LO = 1,
  parameter int SEARCH_HI = 31
) (
  input logic              clk,
  input logic              reset,
  fft_peak_detect_if.slave bus
);
  localparam int CW = $clog2(NBINS);
  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_DRAIN1, S_DRAIN2, S_DRAIN3, S_DONE} state_t;
`ifdef PEAK_SQMAG_EN
  localparam state_t S_LAST = S_DRAIN3;
`else
  localparam state_t S_LAST = S_DRAIN2;
`endif
  state_t r_state, w_next;
  logic w_in_ready, w_busy, w_done, w_acc, w_arm, w_in_range;
  logic [CW-1:0] r_cnt, r_s1_tag, r_max_bin, r_peak_bin;
  logic r_s1_vld, r_peak_found;
  logic [32:0] r_min_mag, r_s1_mag, r_max_mag, r_peak_mag;
  logic signed [15:0] w_re, w_im;
  assign w_re = bus.i_in_data[31:16];
  assign w_im = bus.i_in_data[15:0];
  assign w_acc = bus.i_in_valid && w_in_ready;
  assign w_arm = r_state == S_IDLE && bus.i_start;
  assign w_in_range = r_s1_tag >= CW'(SEARCH_LO) && r_s1_tag <= CW'(SEARCH_HI);
  // State register
  always_ff @(posedge clk)
    r_state <= reset ? S_IDLE : w_next;
  // Next state: accept NBINS beats, flush the pipeline, then report
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = bus.i_start ? S_ACCEPT : S_IDLE;
      S_ACCEPT: w_next = (w_acc && r_cnt == CW'(NBINS - 1)) ? S_DRAIN1 : S_ACCEPT;
      S_DRAIN1: w_next = S_DRAIN2;
      S_DRAIN2: w_next = (S_LAST == S_DRAIN2) ? S_DONE : S_DRAIN3;
      S_DRAIN3: w_next = S_DONE;
      default:  w_next = S_IDLE;
    endcase
  end
  // Moore outputs decoded from the state
  always_comb begin
    w_in_ready = r_state == S_ACCEPT;
    w_busy     = r_state != S_IDLE;
    w_done     = r_state == S_DONE;
  end
  // Bin tag counter and noise floor latched on an accepted start
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_min_mag <= '0;
    end else if (w_arm) begin
      r_cnt     <= '0;
      r_min_mag <= bus.i_min_mag;
    end else if (w_acc)
      r_cnt <= r_cnt + 1'b1;
  end
`ifdef PEAK_SQMAG_EN
  logic signed [31:0] w_re2, w_im2;
  logic [31:0] r_p_re2, r_p_im2;
  logic [CW-1:0] r_p_tag;
  logic r_p_vld;
  assign w_re2 = w_re * w_re;
  assign w_im2 = w_im * w_im;
  // Square each component, then sum a cycle later to keep the multiplier and adder in separate stages
  always_ff @(posedge clk) begin
    r_p_vld  <= reset ? 1'b0 : w_acc;
    r_p_re2  <= w_re2;
    r_p_im2  <= w_im2;
    r_p_tag  <= r_cnt;
    r_s1_vld <= reset ? 1'b0 : r_p_vld;
    r_s1_mag <= {1'b0, r_p_re2} + {1'b0, r_p_im2};
    r_s1_tag <= r_p_tag;
  end
`else
  logic signed [16:0] w_re17, w_im17;
  logic [16:0] w_abs_re, w_abs_im;
  assign w_re17 = w_re;
  assign w_im17 = w_im;
  assign w_abs_re = w_re17[16] ? -w_re17 : w_re17;
  assign w_abs_im = w_im17[16] ? -w_im17 : w_im17;
  // L1 magnitude in 17 bits so that |-32768| stays exact
  always_ff @(posedge clk) begin
    r_s1_vld <= reset ? 1'b0 : w_acc;
    r_s1_mag <= {16'b0, w_abs_re + w_abs_im};
    r_s1_tag <= r_cnt;
  end
`endif
  // Running maximum over the search window; strict compare keeps the lowest bin on ties
  always_ff @(posedge clk) begin
    if (reset || w_arm) begin
      r_max_mag <= '0;
      r_max_bin <= CW'(SEARCH_LO);
    end else if (r_s1_vld && w_in_range && r_s1_mag > r_max_mag) begin
      r_max_mag <= r_s1_mag;
      r_max_bin <= r_s1_tag;
    end
  end
  // Result registers load on the last drain cycle so they are visible with done
  always_ff @(posedge clk) begin
    if (reset) begin
      r_peak_bin   <= '0;
      r_peak_mag   <= '0;
      r_peak_found <= 1'b0;
    end else if (r_state == S_LAST) begin
      r_peak_bin   <= r_max_bin;
      r_peak_mag   <= r_max_mag;
      r_peak_found <= r_max_mag > r_min_mag;
    end
  end
  assign bus.o_in_ready   = w_in_ready;
  assign bus.o_busy       = w_busy;
  assign bus.o_done       = w_done;
  assign bus.o_peak_bin   = r_peak_bin;
  assign bus.o_peak_mag   = r_peak_mag;
  assign bus.o_peak_found = r_peak_found;
endmodule

// File: tb/tb_fft_peak_detect.sv
// tb_fft_peak_detect: scoreboard bench for fft_peak_detect (honours PEAK_SQMAG_EN)
module tb_fft_peak_detect;
`ifdef PEAK_SQMAG_EN
  localparam int LAT = 4;
  localparam longint M3 = 64'd2147483648;
`else
  localparam int LAT = 3;
  localparam longint M3 = 64'd65536;
`endif
  typedef struct {int bin; longint mag; bit found;} exp_t;
  logic clk = 0, reset;
  fft_peak_detect_if bus();
  fft_peak_detect dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  logic [31:0] fr [64];
  exp_t sb[$];
  int prev_bin;
  longint prev_mag;
  bit prev_found;
  int save_bin;
  longint save_mag;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] bw(input int re, input int im);
    return {16'(re), 16'(im)};
  endfunction
  function automatic longint magf(input logic [31:0] w);
    longint re, im;
    re = longint'($signed(w[31:16]));
    im = longint'($signed(w[15:0]));
`ifdef PEAK_SQMAG_EN
    return re * re + im * im;
`else
    return (re < 0 ? -re : re) + (im < 0 ? -im : im);
`endif
  endfunction
  function automatic exp_t model(input logic [32:0] mm);
    exp_t e;
    e.bin = 1;
    e.mag = 0;
    for (int i = 1; i <= 31; i++)
      if (magf(fr[i]) > e.mag) begin
        e.mag = magf(fr[i]);
        e.bin = i;
      end
    e.found = e.mag > longint'(mm);
    return e;
  endfunction
  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < 64; i++) fr[i] = v;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, bus.o_in_ready, 0);
    chk({tag, "_busy"}, bus.o_busy, 0);
    chk({tag, "_done"}, bus.o_done, 0);
    chk({tag, "_bin"}, bus.o_peak_bin, 0);
    chk({tag, "_mag"}, bus.o_peak_mag, 0);
    chk({tag, "_found"}, bus.o_peak_found, 0);
  endtask
  task automatic run_frame(input logic [32:0] mm, input bit gaps, input bit poke, input int abort_at);
    exp_t e;
    int c;
    @(negedge clk);
    bus.i_start = 1;
    bus.i_min_mag = mm;
    @(negedge clk);
    bus.i_start = 0;
    chk("rdy_s1", bus.o_in_ready, 1);
    chk("busy_s1", bus.o_busy, 1);
    for (int i = 0; i < 64; i++) begin
      if (gaps)
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          bus.i_in_valid = 0;
          bus.i_in_data = $urandom;
          @(negedge clk);
        end
      bus.i_in_valid = 1;
      bus.i_in_data = fr[i];
      bus.i_start = poke && i == 20;
      @(negedge clk);
      bus.i_start = 0;
      if (i == abort_at) begin
        bus.i_in_valid = 0;
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk_reset_vals("abort");
        prev_bin = 0;
        prev_mag = 0;
        prev_found = 0;
        return;
      end
    end
    bus.i_in_valid = 0;
    bus.i_in_data = $urandom;
    sb.push_back(model(mm));
    c = 1;
    chk("rdy_n1", bus.o_in_ready, 0);
    chk("hold_bin", bus.o_peak_bin, 64'(prev_bin));
    chk("hold_mag", bus.o_peak_mag, 64'(prev_mag));
    chk("hold_found", bus.o_peak_found, 64'(prev_found));
    while (!bus.o_done && c < 16) begin
      @(negedge clk);
      c++;
    end
    chk("done_lat", 64'(c), 64'(LAT));
    chk("done_seen", bus.o_done, 1);
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      chk("peak_bin", bus.o_peak_bin, 64'(e.bin));
      chk("peak_mag", bus.o_peak_mag, 64'(e.mag));
      chk("peak_found", bus.o_peak_found, 64'(e.found));
      prev_bin = e.bin;
      prev_mag = e.mag;
      prev_found = e.found;
    end
    @(negedge clk);
    chk("done_once", bus.o_done, 0);
    chk("idle_busy", bus.o_busy, 0);
  endtask
  initial begin
    reset = 1;
    bus.i_start = 0;
    bus.i_in_valid = 0;
    bus.i_in_data = 0;
    bus.i_min_mag = 0;
    prev_bin = 0;
    prev_mag = 0;
    prev_found = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    bus.i_start = 1;
    @(negedge clk);
    bus.i_start = 0;
    reset = 0;
    @(negedge clk);
    chk("rst_start_ign", bus.o_busy, 0);
    fill(0);
    fr[5] = bw(1000, -200);
    run_frame(100, 0, 0, -1);
    chk("a_bin", bus.o_peak_bin, 5);
`ifdef PEAK_SQMAG_EN
    chk("a_mag", bus.o_peak_mag, 1040000);
`else
    chk("a_mag", bus.o_peak_mag, 1200);
`endif
    chk("a_found", bus.o_peak_found, 1);
    fill(bw(1, 1));
    fr[7] = bw(0, 500);
    fr[12] = bw(0, 500);
    run_frame(10, 0, 0, -1);
    chk("tie_bin", bus.o_peak_bin, 7);
    fill(0);
    fr[0] = bw(30000, 0);
    fr[40] = bw(32767, 32767);
    fr[20] = bw(10, 10);
    run_frame(0, 0, 0, -1);
    chk("dc_bin", bus.o_peak_bin, 20);
`ifdef PEAK_SQMAG_EN
    chk("dc_mag", bus.o_peak_mag, 200);
`else
    chk("dc_mag", bus.o_peak_mag, 20);
`endif
    fill(0);
    fr[3] = bw(-32768, -32768);
    run_frame(0, 0, 0, -1);
    chk("min_bin", bus.o_peak_bin, 3);
    chk("min_mag", bus.o_peak_mag, 64'(M3));
    for (int i = 0; i < 64; i++) fr[i] = $urandom;
    run_frame(33'($urandom), 0, 0, -1);
    save_bin = int'(bus.o_peak_bin);
    save_mag = longint'(bus.o_peak_mag);
    run_frame(bus.i_min_mag, 1, 1, -1);
    chk("gap_bin_eq", bus.o_peak_bin, 64'(save_bin));
    chk("gap_mag_eq", bus.o_peak_mag, 64'(save_mag));
    for (int i = 0; i < 64; i++) fr[i] = $urandom;
    run_frame(0, 0, 0, 30);
    fill(0);
    fr[9] = bw(100, -100);
    run_frame(0, 0, 0, -1);
    chk("rst_fr_bin", bus.o_peak_bin, 9);
    fill(0);
    run_frame(0, 0, 0, -1);
    chk("zero_bin", bus.o_peak_bin, 1);
    chk("zero_found", bus.o_peak_found, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
